// File: rtl/hazard_forwarding_unit.sv
// Hazard and forwarding controller for the 5-stage ARM datapath: tracks destination
// registers through EX/MEM/WB and produces load-use stalls, branch squash and operand forward selects.
module hazard_forwarding_unit #(
  parameter int REG_ADDR_W  = 4,
  parameter int PC_REG      = 15,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_rn,
  input  logic [REG_ADDR_W-1:0]  id_rm,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic                   id_rn_used,
  input  logic                   id_rm_used,
  input  logic                   id_rs_used,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   ctrl_reg_write_enable,
  input  logic                   ctrl_mem_to_reg_select,
  input  logic                   branch_taken,
  output logic                   nop_insert,
  output logic                   pc_enable,
  output logic                   if_id_enable,
  output logic                   if_id_flush,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [1:0]             fwd_c_sel,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  logic [REG_ADDR_W-1:0]  ex_rd_r, mem_rd_r, wb_rd_r;
  logic                   ex_we_r, mem_we_r, wb_we_r;
  logic                   ex_load_r;
  logic [STALL_CNT_W-1:0] stall_count_r;

  logic                   load_use_s;
  logic                   nop_insert_s;
  logic [1:0]             fwd_a_s, fwd_b_s, fwd_c_s;

  function automatic logic op_match(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  we,
    input logic [REG_ADDR_W-1:0] rd
  );
    return used & (src != PC_ADDR) & we & (src == rd);
  endfunction

  // An EX hit on a load falls through to older stages; the stall makes the select irrelevant then.
  function automatic logic [1:0] fwd_select(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic                  ex_we,
    input logic                  ex_load,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  mem_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic                  wb_we
  );
    logic [1:0] sel;
    if (op_match(used, src, ex_we, ex_rd) && !ex_load) begin
      sel = SEL_EX;
    end else if (op_match(used, src, mem_we, mem_rd)) begin
      sel = SEL_MEM;
    end else if (op_match(used, src, wb_we, wb_rd)) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Load-use detection and forward-select computation from ID operands and shadow state.
  always_comb begin
    load_use_s = ex_load_r & (op_match(id_rn_used, id_rn, ex_we_r, ex_rd_r) |
                              op_match(id_rm_used, id_rm, ex_we_r, ex_rd_r) |
                              op_match(id_rs_used, id_rs, ex_we_r, ex_rd_r));
    fwd_a_s = fwd_select(id_rn_used, id_rn, ex_rd_r, ex_we_r, ex_load_r,
                         mem_rd_r, mem_we_r, wb_rd_r, wb_we_r);
    fwd_b_s = fwd_select(id_rm_used, id_rm, ex_rd_r, ex_we_r, ex_load_r,
                         mem_rd_r, mem_we_r, wb_rd_r, wb_we_r);
    fwd_c_s = fwd_select(id_rs_used, id_rs, ex_rd_r, ex_we_r, ex_load_r,
                         mem_rd_r, mem_we_r, wb_rd_r, wb_we_r);
  end

  // Pipeline control outputs; a taken branch squashes ID but keeps fetching the target.
  always_comb begin
    nop_insert_s = 1'b0;
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    if_id_flush  = 1'b0;
    fwd_a_sel    = SEL_RF;
    fwd_b_sel    = SEL_RF;
    fwd_c_sel    = SEL_RF;
    if (reset) begin
      nop_insert_s = 1'b0;
    end else begin
      fwd_a_sel = fwd_a_s;
      fwd_b_sel = fwd_b_s;
      fwd_c_sel = fwd_c_s;
      if (branch_taken) begin
        nop_insert_s = 1'b1;
        if_id_flush  = 1'b1;
      end else if (load_use_s) begin
        nop_insert_s = 1'b1;
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
      end else begin
        nop_insert_s = 1'b0;
      end
    end
  end

  assign nop_insert  = nop_insert_s;
  assign stall_count = stall_count_r;

  // Shadow pipeline advance; a bubble enters EX with its write and load flags cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd_r   <= {REG_ADDR_W{1'b0}};
      ex_we_r   <= 1'b0;
      ex_load_r <= 1'b0;
      mem_rd_r  <= {REG_ADDR_W{1'b0}};
      mem_we_r  <= 1'b0;
      wb_rd_r   <= {REG_ADDR_W{1'b0}};
      wb_we_r   <= 1'b0;
    end else begin
      ex_rd_r   <= id_rd;
      ex_we_r   <= ctrl_reg_write_enable & ~nop_insert_s;
      ex_load_r <= ctrl_mem_to_reg_select & ctrl_reg_write_enable & ~nop_insert_s;
      mem_rd_r  <= ex_rd_r;
      mem_we_r  <= ex_we_r;
      wb_rd_r   <= mem_rd_r;
      wb_we_r   <= mem_we_r;
    end
  end

  // Saturating count of real load-use stall cycles; branch-squashed hazards are not stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= {STALL_CNT_W{1'b0}};
    end else if (load_use_s && !branch_taken && !(&stall_count_r)) begin
      stall_count_r <= stall_count_r + STALL_CNT_W'(1);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Randomized bench for hazard_forwarding_unit against a list-of-stages reference model.
module tb_hazard_forwarding_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rn, id_rm, id_rs, id_rd;
  logic       id_rn_used, id_rm_used, id_rs_used;
  logic       ctrl_reg_write_enable, ctrl_mem_to_reg_select, branch_taken;

  logic        nop_insert, pc_enable, if_id_enable, if_id_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_c_sel;
  logic [15:0] stall_count;
  logic        s_nop_insert, s_pc_enable, s_if_id_enable, s_if_id_flush;
  logic [1:0]  s_fwd_a_sel, s_fwd_b_sel, s_fwd_c_sel;
  logic [3:0]  s_stall_count;

  always #5 clk = ~clk;

  hazard_forwarding_unit dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .ctrl_reg_write_enable(ctrl_reg_write_enable),
    .ctrl_mem_to_reg_select(ctrl_mem_to_reg_select), .branch_taken(branch_taken),
    .nop_insert(nop_insert), .pc_enable(pc_enable), .if_id_enable(if_id_enable),
    .if_id_flush(if_id_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .fwd_c_sel(fwd_c_sel), .stall_count(stall_count)
  );

  hazard_forwarding_unit #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .ctrl_reg_write_enable(ctrl_reg_write_enable),
    .ctrl_mem_to_reg_select(ctrl_mem_to_reg_select), .branch_taken(branch_taken),
    .nop_insert(s_nop_insert), .pc_enable(s_pc_enable), .if_id_enable(s_if_id_enable),
    .if_id_flush(s_if_id_flush), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
    .fwd_c_sel(s_fwd_c_sel), .stall_count(s_stall_count)
  );

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [3:0]  st_rd [3];
  bit          st_we [3];
  bit          st_ld [3];
  int unsigned cnt16, cnt4;
  bit          m_hz, m_nop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int unsigned src_of(input bit used, input logic [3:0] r);
    if (!used || r == 4'd15) return 0;
    for (int s = 0; s < 3; s++)
      if (st_we[s] && st_rd[s] == r) return s + 1;
    return 0;
  endfunction

  function automatic bit waits_on_load(input bit used, input logic [3:0] r);
    return used && r != 4'd15 && st_ld[0] && st_rd[0] == r;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) begin
      st_rd[s] = 4'd0; st_we[s] = 1'b0; st_ld[s] = 1'b0;
    end
    cnt16 = 0; cnt4 = 0;
  endtask

  task automatic model_check();
    bit both_fwd;
    m_hz = waits_on_load(id_rn_used, id_rn) || waits_on_load(id_rm_used, id_rm) ||
           waits_on_load(id_rs_used, id_rs);
    m_nop = !reset && (branch_taken || m_hz);
    chk("nop_insert",   {31'd0, nop_insert},   {31'd0, m_nop});
    chk("pc_enable",    {31'd0, pc_enable},    {31'd0, reset || branch_taken || !m_hz});
    chk("if_id_enable", {31'd0, if_id_enable}, {31'd0, reset || branch_taken || !m_hz});
    chk("if_id_flush",  {31'd0, if_id_flush},  {31'd0, !reset && branch_taken});
    chk("sat_nop",      {31'd0, s_nop_insert}, {31'd0, m_nop});
    chk("stall_count",  {16'd0, stall_count},  cnt16);
    chk("stall_sat",    {28'd0, s_stall_count}, cnt4);
    both_fwd = !m_nop;
    if (both_fwd) begin
      chk("fwd_a_sel", {30'd0, fwd_a_sel}, reset ? 0 : src_of(id_rn_used, id_rn));
      chk("fwd_b_sel", {30'd0, fwd_b_sel}, reset ? 0 : src_of(id_rm_used, id_rm));
      chk("fwd_c_sel", {30'd0, fwd_c_sel}, reset ? 0 : src_of(id_rs_used, id_rs));
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
    end else begin
      if (m_hz && !branch_taken) begin
        if (cnt16 != 32'hFFFF) cnt16++;
        if (cnt4 != 15) cnt4++;
      end
      for (int s = 2; s > 0; s--) begin
        st_rd[s] = st_rd[s-1]; st_we[s] = st_we[s-1]; st_ld[s] = st_ld[s-1];
      end
      st_rd[0] = id_rd;
      st_we[0] = ctrl_reg_write_enable && !m_nop;
      st_ld[0] = ctrl_reg_write_enable && ctrl_mem_to_reg_select && !m_nop;
    end
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_instr(input logic [3:0] rd, input bit we, input bit ld,
                           input logic [3:0] rn, input bit rn_u,
                           input logic [3:0] rm, input bit rm_u, input bit br);
    id_rd = rd; ctrl_reg_write_enable = we; ctrl_mem_to_reg_select = ld;
    id_rn = rn; id_rn_used = rn_u; id_rm = rm; id_rm_used = rm_u;
    id_rs = 4'd0; id_rs_used = 1'b0; branch_taken = br;
  endtask

  task automatic rand_inputs(input int unsigned span);
    id_rn = 4'($urandom_range(span)); id_rm = 4'($urandom_range(span));
    id_rs = 4'($urandom_range(span)); id_rd = 4'($urandom_range(span));
    if ($urandom_range(7) == 0) id_rn = 4'd15;
    if ($urandom_range(7) == 0) id_rd = 4'd15;
    id_rn_used = 1'($urandom); id_rm_used = 1'($urandom); id_rs_used = 1'($urandom);
    ctrl_reg_write_enable = ($urandom_range(3) != 0);
    ctrl_mem_to_reg_select = 1'($urandom);
    branch_taken = ($urandom_range(7) == 0);
  endtask

  int unsigned saved;

  initial begin
    reset = 1'b1;
    rand_inputs(15);
    @(posedge clk);
    model_clear();
    #1;
    // Reset held two cycles with arbitrary inputs.
    for (int i = 0; i < 2; i++) begin
      rand_inputs(15);
      #1;
      chk("rst_nop", {31'd0, nop_insert}, 32'd0);
      chk("rst_pc_en", {31'd0, pc_enable}, 32'd1);
      chk("rst_fwd", {26'd0, fwd_a_sel, fwd_b_sel, fwd_c_sel}, 32'd0);
      chk("rst_cnt", {16'd0, stall_count}, 32'd0);
      cycle();
    end
    reset = 1'b0;

    // Load-use: LDR R3 then ADD reading R3 via rn.
    set_instr(4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle();
    set_instr(4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
    #1;
    chk("lu_nop", {31'd0, nop_insert}, 32'd1);
    chk("lu_pc_en", {31'd0, pc_enable}, 32'd0);
    chk("lu_ifid_en", {31'd0, if_id_enable}, 32'd0);
    cycle();
    #1;
    chk("lu_release", {31'd0, nop_insert}, 32'd0);
    chk("lu_fwd_mem", {30'd0, fwd_a_sel}, 32'd2);
    chk("lu_count", {16'd0, stall_count}, 32'd1);
    cycle();

    // ALU forwarding priority on operand B.
    for (int i = 0; i < 3; i++) begin
      set_instr(4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      cycle();
    end
    set_instr(4'd6, 1'b0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    #1;
    chk("fwd_b_ex_first", {30'd0, fwd_b_sel}, 32'd1);
    cycle();
    cycle();
    #1;
    chk("fwd_b_wb_only", {30'd0, fwd_b_sel}, 32'd3);
    cycle();

    // PC register is never forwarded nor stalled on, even as a load target.
    set_instr(4'd15, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle();
    set_instr(4'd1, 1'b0, 1'b0, 4'd15, 1'b1, 4'd0, 1'b0, 1'b0);
    #1;
    chk("pc_no_stall", {31'd0, nop_insert}, 32'd0);
    chk("pc_no_fwd", {30'd0, fwd_a_sel}, 32'd0);
    cycle();

    // Branch overriding a load-use hazard.
    saved = stall_count;
    set_instr(4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle();
    set_instr(4'd8, 1'b1, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b1);
    #1;
    chk("br_flush", {31'd0, if_id_flush}, 32'd1);
    chk("br_nop", {31'd0, nop_insert}, 32'd1);
    chk("br_pc_en", {31'd0, pc_enable}, 32'd1);
    cycle();
    set_instr(4'd9, 1'b1, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0);
    #1;
    chk("br_no_bubble_hz", {31'd0, nop_insert}, 32'd0);
    chk("br_cnt_held", {16'd0, stall_count}, saved);
    cycle();

    // Twenty load-use stalls drive the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++) begin
      set_instr(4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      cycle();
      set_instr(4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
      cycle();
      cycle();
    end
    #1;
    chk("sat_hold", {28'd0, s_stall_count}, 32'd15);
    cycle();

    // Reset in the middle of a stall leaves no stall afterwards.
    set_instr(4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle();
    set_instr(4'd3, 1'b1, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    chk("post_rst_no_stall", {31'd0, nop_insert}, 32'd0);
    cycle();

    // Random traffic on a small register window to provoke frequent hazards.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs((i % 2 == 0) ? 3 : 15);
      reset = ($urandom_range(99) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
